// File: rtl/taptempo_pkg.sv
// Shared encodings for the TapTempo debounce logic.
// Channel state encoding matches the original per-button debouncer, so waveforms and
// downstream decode stay compatible.
package taptempo_pkg;

  // Per-channel debounce state
  localparam logic [1:0] S_WAIT_LOW  = 2'd0;
  localparam logic [1:0] S_WAIT_HIGH = 2'd1;
  localparam logic [1:0] S_CNT_HIGH  = 2'd2;
  localparam logic [1:0] S_CNT_LOW   = 2'd3;

  // Scan scheduler state
  localparam logic SCH_IDLE = 1'b0;
  localparam logic SCH_SCAN = 1'b1;

  // Simulation shortens the debounce window so a full window is only a few scans long.
`ifdef COCOTB_SIM
  localparam int unsigned DEBOUNCE_PER_NS_DEFAULT = 40960;
`else
  localparam int unsigned DEBOUNCE_PER_NS_DEFAULT = 20_971_520;
`endif

  // The debounced level is high while counting up or settled high.
  function automatic logic state_is_high(input logic [1:0] st);
    return (st == S_CNT_HIGH) || (st == S_WAIT_HIGH);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs.
// Ports:
//   clk_i   - destination clock
//   rst_ni  - asynchronous active-low reset
//   d_i     - asynchronous input bits
//   q_o     - synchronised bits, two clk_i cycles behind d_i
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Time-multiplexed button debouncer. Each tp_i pulse triggers one scan that visits every
// channel once, in order, one channel per clk_i cycle. A single incrementer/comparator is
// shared by all channels; per-channel state and counters live in flop arrays.
// Ports:
//   clk_i    - system clock
//   rst_ni   - asynchronous active-low reset
//   tp_i     - timepulse, one clk_i cycle wide
//   btn_i    - raw button levels (asynchronous)
//   btn_o    - debounced levels
//   press_o  - one-cycle strobe on a debounced rising edge
//   busy_o   - scan in progress
//   ovf_o    - sticky: a timepulse was lost
module debounce_scan_ctrl
  import taptempo_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned PULSE_PER_NS    = 5120,
  parameter int unsigned DEBOUNCE_PER_NS = DEBOUNCE_PER_NS_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tp_i,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] btn_o,
  output logic [N_BTN-1:0] press_o,
  output logic             busy_o,
  output logic             ovf_o
);

  localparam int unsigned MAX_COUNT = DEBOUNCE_PER_NS / PULSE_PER_NS;
  localparam int unsigned CNT_W     = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam int unsigned IDX_W     = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BTN - 1);

  logic [N_BTN-1:0] s_btn;

  sync2 #(
    .WIDTH (N_BTN)
  ) u_sync2 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (btn_i),
    .q_o    (s_btn)
  );

  // Scheduler
  logic             sch_q, sch_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pend_q, pend_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    sch_d  = sch_q;
    idx_d  = idx_q;
    pend_d = pend_q;
    // A pulse arriving while one is already queued can never be served separately.
    ovf_d  = ovf_q | (tp_i & pend_q);
    unique case (sch_q)
      SCH_IDLE: begin
        if (tp_i || pend_q) begin
          sch_d  = SCH_SCAN;
          idx_d  = '0;
          pend_d = 1'b0;
        end
      end
      SCH_SCAN: begin
        if (tp_i) pend_d = 1'b1;
        if (idx_q == IDX_LAST) begin
          sch_d = SCH_IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: sch_d = SCH_IDLE;
    endcase
  end

  // Channel datapath, shared across channels via idx_q
  logic [1:0]       state_q [N_BTN];
  logic [1:0]       state_d [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];
  logic [CNT_W-1:0] cnt_d   [N_BTN];
  logic [N_BTN-1:0] press_q, press_d;

  logic [1:0]       cur_state, nxt_state;
  logic [CNT_W-1:0] cur_cnt, nxt_cnt;
  logic             cur_in;

  assign cur_state = state_q[idx_q];
  assign cur_cnt   = cnt_q[idx_q];
  assign cur_in    = s_btn[idx_q];

  always_comb begin
    nxt_state = cur_state;
    nxt_cnt   = cur_cnt;
    unique case (cur_state)
      S_WAIT_LOW: begin
        if (cur_in) begin
          nxt_state = S_CNT_HIGH;
          nxt_cnt   = '0;
        end
      end
      // Input is ignored while counting; this is what swallows bounce.
      S_CNT_HIGH: begin
        if (cur_cnt == CNT_LAST) begin
          nxt_state = S_WAIT_HIGH;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cur_cnt + CNT_W'(1);
        end
      end
      S_WAIT_HIGH: begin
        if (!cur_in) begin
          nxt_state = S_CNT_LOW;
          nxt_cnt   = '0;
        end
      end
      S_CNT_LOW: begin
        if (cur_cnt == CNT_LAST) begin
          nxt_state = S_WAIT_LOW;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cur_cnt + CNT_W'(1);
        end
      end
      default: nxt_state = S_WAIT_LOW;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = '0;
    if (sch_q == SCH_SCAN) begin
      state_d[idx_q] = nxt_state;
      cnt_d[idx_q]   = nxt_cnt;
      press_d[idx_q] = (cur_state == S_WAIT_LOW) && (nxt_state == S_CNT_HIGH);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sch_q   <= SCH_IDLE;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      state_q <= '{default: S_WAIT_LOW};
      cnt_q   <= '{default: '0};
      press_q <= '0;
    end else begin
      sch_q   <= sch_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    btn_o = '0;
    for (int k = 0; k < N_BTN; k++) begin
      btn_o[k] = state_is_high(state_q[k]);
    end
  end

  assign press_o = press_q;
  assign busy_o  = (sch_q == SCH_SCAN);
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Bench for debounce_scan_ctrl with N_BTN=4 and a window of 8 visits. The reference model
// tracks, per channel, the debounced level and how many more visits it stays locked.
module tb_debounce_scan_ctrl;

  localparam int N    = 4;
  localparam int MAXC = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         tp    = 1'b0;
  logic [N-1:0] btn   = '0;
  logic [N-1:0] btn_o;
  logic [N-1:0] press_o;
  logic         busy_o;
  logic         ovf_o;

  debounce_scan_ctrl #(
    .N_BTN           (N),
    .PULSE_PER_NS    (5120),
    .DEBOUNCE_PER_NS (40960)
  ) u_dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .tp_i    (tp),
    .btn_i   (btn),
    .btn_o   (btn_o),
    .press_o (press_o),
    .busy_o  (busy_o),
    .ovf_o   (ovf_o)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [N-1:0] m_s1 = '0, m_s2 = '0;
  logic [N-1:0] m_level = '0;
  logic [N-1:0] m_press = '0;
  int           m_lock [N] = '{default: 0};
  int           m_pos  = -1;  // channel being visited this cycle, -1 when idle
  bit           m_pend = 1'b0;
  bit           m_ovf  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0;
      for (int k = 0; k < N; k++) m_lock[k] = 0;
      m_pos = -1; m_pend = 1'b0; m_ovf = 1'b0;
    end else begin
      m_press = '0;
      if (m_pos >= 0) begin
        if (m_lock[m_pos] > 0) begin
          m_lock[m_pos] = m_lock[m_pos] - 1;
        end else if (m_s2[m_pos] != m_level[m_pos]) begin
          m_level[m_pos] = m_s2[m_pos];
          m_lock[m_pos]  = MAXC;
          if (m_s2[m_pos]) m_press[m_pos] = 1'b1;
        end
      end
      if (tp && m_pend) m_ovf = 1'b1;
      if (m_pos < 0) begin
        if (tp || m_pend) begin
          m_pos  = 0;
          m_pend = 1'b0;
        end
      end else begin
        if (tp) m_pend = 1'b1;
        m_pos = (m_pos == N - 1) ? -1 : m_pos + 1;
      end
      m_s2 = m_s1;
      m_s1 = btn;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int tp_period = 10;
  int p0_cnt = 0;
  int press_cyc [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Compare outputs at the falling edge, then drive inputs for the next rising edge.
  task automatic step(input logic [N-1:0] b);
    @(negedge clk);
    check("btn_o", 32'(btn_o), 32'(m_level));
    check("press_o", 32'(press_o), 32'(m_press));
    check("busy_o", 32'(busy_o), 32'(m_pos >= 0));
    check("ovf_o", 32'(ovf_o), 32'(m_ovf));
    for (int k = 0; k < N; k++) begin
      if (press_o[k] && press_cyc[k] < 0) press_cyc[k] = cyc;
    end
    if (press_o[0]) p0_cnt++;
    cyc++;
    btn = b;
    tp  = rst_n && (cyc % tp_period == 0);
  endtask

  logic [N-1:0] cur;
  logic         b0;
  int           guard;

  initial begin
    for (int k = 0; k < N; k++) press_cyc[k] = -1;
    #1 rst_n = 1'b0;

    // Reset held while inputs toggle
    repeat (6) step(N'($urandom));
    check("rst_btn_o", 32'(btn_o), 0);
    check("rst_busy_o", 32'(busy_o), 0);
    rst_n = 1'b1;
    repeat (15) step('0);

    // Clean press and release on ch2
    repeat (150) step(4'b0100);
    check("ch2_pressed", 32'(press_cyc[2] >= 0), 1);
    check("ch2_held", 32'(btn_o[2]), 1);
    repeat (150) step('0);
    check("ch2_released", 32'(btn_o[2]), 0);

    // Bounce on ch0
    p0_cnt = 0;
    b0 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i > 0 && i % 3 == 0) b0 = ~b0;
      step({3'b000, b0});
    end
    repeat (120) step(4'b0001);
    check("bounce_press_cnt", 32'(p0_cnt), 1);
    repeat (200) step('0);

    // Simultaneous press, applied mid-period so the sync chain settles before the scan
    for (int k = 0; k < N; k++) press_cyc[k] = -1;
    guard = 0;
    while ((cyc % tp_period) != 5 && guard < 20) begin
      step('0);
      guard++;
    end
    repeat (150) step('1);
    for (int k = 1; k < N; k++) begin
      check("simul_order", 32'(press_cyc[k] - press_cyc[0]), 32'(k));
    end
    repeat (200) step('0);

    // Random slow toggling
    cur = '0;
    repeat (600) begin
      if ($urandom_range(15) == 0) cur[$urandom_range(N - 1)] ^= 1'b1;
      step(cur);
    end

    // Timepulses too close together
    tp_period = 2;
    repeat (20) step(cur);
    check("ovf_sticky", 32'(ovf_o), 1);
    tp_period = 10;
    repeat (100) begin
      if ($urandom_range(15) == 0) cur[$urandom_range(N - 1)] ^= 1'b1;
      step(cur);
    end

    // Reset in the middle of a scan
    guard = 0;
    while (m_pos != 2 && guard < 60) begin
      step(cur);
      guard++;
    end
    check("midscan_busy_before", 32'(busy_o), 1);
    tp    = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy_o), 0);
    check("midrst_btn", 32'(btn_o), 0);
    check("midrst_press", 32'(press_o), 0);
    check("midrst_ovf", 32'(ovf_o), 0);
    repeat (3) step(cur);
    rst_n = 1'b1;
    repeat (300) begin
      if ($urandom_range(15) == 0) cur[$urandom_range(N - 1)] ^= 1'b1;
      step(cur);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
